pipeline_trace_arbiter: RTL and testbench

Collects per-stage trace events from the five pipeline stages of the out-of-order core (fetch, decode, rename, issue, commit) and serialises them onto one trace channel, one event per cycle. Each stage gets a one-entry holding slot. A round-robin arbiter picks among occupied slots and loads a registered output stage, which also stamps a global sequence number. The block sits beside the core and feeds the trace sink, so the core never stalls on logging unless a slot is still occupied.

---
 rtl/pipeline_trace_arbiter.sv | 92 +++++++++
 tb/tb_pipeline_trace_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_arbiter.sv
// Serialises trace events from the core's pipeline stages onto one channel.
// Each stage has a one-entry slot, a round-robin arbiter picks among them, and a registered output stage adds a sequence stamp.
module pipeline_trace_arbiter #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned NUM_FIELDS = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEQ_W      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_STAGES-1:0]                  in_valid,
  output logic [NUM_STAGES-1:0]                  in_ready,
  input  logic [NUM_STAGES*NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(NUM_STAGES)-1:0]          out_stage,
  output logic [NUM_FIELDS*DATA_W-1:0]           out_data,
  output logic [SEQ_W-1:0]                       out_seq
);

  localparam int unsigned EV_W  = NUM_FIELDS * DATA_W;
  localparam int unsigned STG_W = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0] slot_valid;
  logic [EV_W-1:0]       slot_data [NUM_STAGES];
  logic [STG_W-1:0]      rr_ptr;
  logic [SEQ_W-1:0]      seq_cnt;

  logic                  grant_found_c;
  logic [STG_W-1:0]      grant_idx_c;
  logic                  load_c;

  // First occupied slot at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr) + k) % NUM_STAGES;
      if (!grant_found_c && slot_valid[STG_W'(cand)]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = STG_W'(cand);
      end
    end
  end

  assign load_c = (!out_valid || out_ready) && grant_found_c;

  // A granted slot can refill in the same cycle it is drained.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      in_ready[i] = rst_n && (!slot_valid[i] || (load_c && (grant_idx_c == STG_W'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        slot_data[i] <= '0;
      end
      rr_ptr    <= '0;
      seq_cnt   <= '0;
      out_valid <= 1'b0;
      out_stage <= '0;
      out_data  <= '0;
      out_seq   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= in_data[i*EV_W +: EV_W];
        end else if (load_c && (grant_idx_c == STG_W'(i))) begin
          slot_valid[i] <= 1'b0;
        end
      end

      if (load_c) begin
        out_valid <= 1'b1;
        out_stage <= grant_idx_c;
        out_data  <= slot_data[grant_idx_c];
        out_seq   <= seq_cnt;
        seq_cnt   <= seq_cnt + SEQ_W'(1);
        rr_ptr    <= (grant_idx_c == STG_W'(NUM_STAGES - 1)) ? '0 : grant_idx_c + STG_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_trace_arbiter.sv
// Bench for pipeline_trace_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_pipeline_trace_arbiter;

  localparam int N   = 5;
  localparam int F   = 6;
  localparam int DW  = 32;
  localparam int BLK = F * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     in_valid = '0;
  logic [N-1:0]     in_ready;
  logic [N*BLK-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_stage;
  logic [BLK-1:0]   out_data;
  logic [31:0]      out_seq;

  logic [N-1:0]     w_in_ready;
  logic             w_out_valid;
  logic [2:0]       w_out_stage;
  logic [BLK-1:0]   w_out_data;
  logic [3:0]       w_out_seq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_trace_arbiter #(.NUM_STAGES(N), .NUM_FIELDS(F), .DATA_W(DW), .SEQ_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
    .out_data(out_data), .out_seq(out_seq)
  );

  // Narrow sequence counter instance, to exercise wrap-around in few events.
  pipeline_trace_arbiter #(.NUM_STAGES(N), .NUM_FIELDS(F), .DATA_W(DW), .SEQ_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_stage(w_out_stage),
    .out_data(w_out_data), .out_seq(w_out_seq)
  );

  // Reference model state: occupied slots, round-robin start, next stamp, current output.
  bit             m_init = 1'b0;
  bit             m_sv [N];
  logic [BLK-1:0] m_sd [N];
  bit             m_acc [N];
  int             m_rr = 0;
  logic [31:0]    m_seq = '0;
  bit             m_ov = 1'b0;
  int             m_os = 0;
  logic [BLK-1:0] m_od = '0;
  logic [31:0]    m_oseq = '0;

  task automatic cmp(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (m_sv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    bit ld;
    logic [N-1:0] r;
    g  = pick();
    ld = (!m_ov || out_ready) && (g >= 0);
    for (int i = 0; i < N; i++) r[i] = rst_n && (!m_sv[i] || (ld && g == i));
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_sv[i] = 1'b0; m_sd[i] = '0; m_acc[i] = 1'b0;
      end
      m_rr = 0; m_seq = '0; m_ov = 1'b0; m_os = 0; m_od = '0; m_oseq = '0;
      m_init = 1'b1;
    end else begin
      int g;
      bit ld;
      logic [N-1:0] r;
      r  = exp_ready();
      g  = pick();
      ld = (!m_ov || out_ready) && (g >= 0);
      for (int i = 0; i < N; i++) m_acc[i] = in_valid[i] && r[i];
      if (ld) begin
        m_os = g; m_od = m_sd[g]; m_oseq = m_seq; m_ov = 1'b1;
        m_sv[g] = 1'b0;
        m_rr = (g + 1) % N;
        m_seq = m_seq + 32'd1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) begin
          m_sv[i] = 1'b1;
          m_sd[i] = in_data[i*BLK +: BLK];
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_init) begin
      logic [N-1:0] er;
      er = exp_ready();
      cmp("in_ready",   BLK'(in_ready),    BLK'(er));
      cmp("out_valid",  BLK'(out_valid),   BLK'(m_ov));
      cmp("out_stage",  BLK'(out_stage),   BLK'(m_os));
      cmp("out_data",   out_data,          m_od);
      cmp("out_seq",    BLK'(out_seq),     BLK'(m_oseq));
      cmp("w_in_ready", BLK'(w_in_ready),  BLK'(er));
      cmp("w_out_valid", BLK'(w_out_valid), BLK'(m_ov));
      cmp("w_out_stage", BLK'(w_out_stage), BLK'(m_os));
      cmp("w_out_data", w_out_data,        m_od);
      cmp("w_out_seq",  BLK'(w_out_seq),   BLK'(m_oseq[3:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    #1;
    cmp("rst_in_ready", BLK'(in_ready), '0);
    tick();
    cmp("rst_out_valid", BLK'(out_valid), '0);
    cmp("rst_out_seq", BLK'(out_seq), '0);
    rst_n = 1'b1;
  endtask

  task automatic rand_data(input int i);
    for (int f = 0; f < F; f++) in_data[(i*F+f)*DW +: DW] = $urandom;
  endtask

  task automatic rand_phase(input int cycles, input int rate, input int rdy);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !m_acc[i])) begin
          in_valid[i] = ($urandom_range(99) < rate);
          rand_data(i);
        end
      end
      out_ready = ($urandom_range(99) < rdy);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sv[i] = 1'b0; m_sd[i] = '0; m_acc[i] = 1'b0;
    end

    // Single event from stage 2.
    do_reset();
    out_ready = 1'b1;
    rand_data(2);
    in_data[2*BLK +: DW] = 32'h0040_0010;
    in_valid = 5'b00100;
    #1;
    cmp("t1_ready_pre", BLK'(in_ready[2]), BLK'(1'b1));
    tick();
    in_valid = '0;
    cmp("t1_ready_mid", BLK'(in_ready[2]), BLK'(1'b1));
    tick();
    cmp("t1_valid", BLK'(out_valid), BLK'(1'b1));
    cmp("t1_stage", BLK'(out_stage), BLK'(3'd2));
    cmp("t1_pc", BLK'(out_data[31:0]), BLK'(32'h0040_0010));
    cmp("t1_seq", BLK'(out_seq), '0);
    cmp("t1_ready_post", BLK'(in_ready[2]), BLK'(1'b1));

    // All five stages at once.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_data(i);
    in_valid = 5'h1f;
    tick();
    in_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      cmp("t2_valid", BLK'(out_valid), BLK'(1'b1));
      cmp("t2_stage", BLK'(out_stage), BLK'(k));
      cmp("t2_seq", BLK'(out_seq), BLK'(k));
    end
    tick();
    cmp("t2_idle", BLK'(out_valid), '0);

    // Sink backpressure with stages 1 and 3 waiting.
    do_reset();
    out_ready = 1'b0;
    rand_data(0);
    in_data[0 +: DW] = 32'h1111_0000;
    in_valid = 5'b00001;
    tick();
    for (int i = 1; i < N; i += 2) rand_data(i);
    in_data[1*BLK +: DW] = 32'h2222_0001;
    in_data[3*BLK +: DW] = 32'h3333_0003;
    in_valid = 5'b01010;
    tick();
    in_valid = '0;
    cmp("t3_valid", BLK'(out_valid), BLK'(1'b1));
    for (int k = 0; k < 3; k++) begin
      cmp("t3_hold_stage", BLK'(out_stage), '0);
      cmp("t3_hold_pc", BLK'(out_data[31:0]), BLK'(32'h1111_0000));
      cmp("t3_hold_seq", BLK'(out_seq), '0);
      cmp("t3_full", BLK'({in_ready[3], in_ready[1]}), '0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    tick();
    cmp("t3_rel1_stage", BLK'(out_stage), BLK'(3'd1));
    cmp("t3_rel1_pc", BLK'(out_data[31:0]), BLK'(32'h2222_0001));
    cmp("t3_rel1_seq", BLK'(out_seq), BLK'(1));
    tick();
    cmp("t3_rel2_stage", BLK'(out_stage), BLK'(3'd3));
    cmp("t3_rel2_pc", BLK'(out_data[31:0]), BLK'(32'h3333_0003));
    cmp("t3_rel2_seq", BLK'(out_seq), BLK'(2));
    tick();
    cmp("t3_idle", BLK'(out_valid), '0);

    // Stages 0 and 4 streaming: strict alternation.
    do_reset();
    out_ready = 1'b1;
    rand_data(0); rand_data(4);
    in_valid = 5'b10001;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp("t4_valid", BLK'(out_valid), BLK'(1'b1));
      cmp("t4_stage", BLK'(out_stage), BLK'((k % 2 == 0) ? 4'd0 : 4'd4));
    end
    in_valid = '0;

    // Sequence wrap on the 4-bit instance, round robin across all stages.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_data(i);
    in_valid = 5'h1f;
    tick();
    for (int k = 0; k < 18; k++) begin
      tick();
      cmp("t5_wseq", BLK'(w_out_seq), BLK'(k % 16));
      cmp("t5_stage", BLK'(w_out_stage), BLK'(k % N));
    end
    in_valid = '0;

    // Reset while slots are occupied and the output is pending.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rand_data(i);
    in_valid = 5'b01111;
    tick();
    in_valid = '0;
    tick();
    cmp("t6_pending", BLK'(out_valid), BLK'(1'b1));
    rst_n = 1'b0;
    #1;
    cmp("t6_rst_ready", BLK'(in_ready), '0);
    tick();
    cmp("t6_rst_valid", BLK'(out_valid), '0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    rand_data(3);
    in_valid = 5'b01000;
    tick();
    in_valid = '0;
    tick();
    cmp("t6_valid", BLK'(out_valid), BLK'(1'b1));
    cmp("t6_stage", BLK'(out_stage), BLK'(3'd3));
    cmp("t6_seq", BLK'(out_seq), '0);

    // Randomized traffic under varied load and sink behaviour.
    rand_phase(700, 30, 90);
    rand_phase(700, 80, 40);
    rand_phase(700, 60, 75);
    rst_n = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
